tdm_demux: RTL and testbench

//  Registered time-division demultiplexer; the inverse of the mux primitive.
//  - Takes a serial stream of DATA_WIDTH words, one lane per valid cycle, round-robin.
//  - Assembles 2**SELECT_LINES words into one wide frame and presents it with a 1-cycle valid strobe.
//  - Sits at the receive end of TDM links whose transmit end steps mux.select through each lane.

---
 rtl/tdm_demux.sv | 134 +++++++++++++
 tb/tb_tdm_demux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux -- registered time-division demultiplexer.
//
// Collects a round-robin serial stream of DATA_WIDTH words (one lane per
// valid cycle) into a frame of N = 2**SELECT_LINES lanes. The frame is
// presented on data_out with a one-cycle data_out_valid strobe, issued on
// the clock edge that captures the last lane word.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active-high
//   data_in        : serial lane word
//   data_in_valid  : data_in is valid this cycle
//   sync_in        : frame start marker; a valid word carrying it is lane 0
//   data_out       : assembled frame, lane k at [DATA_WIDTH*k +: DATA_WIDTH]
//   data_out_valid : one-cycle strobe, new frame on data_out
//   sync_out       : qualifies the strobe; the frame was opened by sync_in
//   select_out     : lane the next valid word will fill
//   frame_err      : sticky, sync_in arrived with a partial frame pending
module tdm_demux #(
   parameter          BLOCK_NAME   = "tdm_demux",
   parameter int      X            = 0,
   parameter int      Y            = 0,
   parameter int      DX           = 0,
   parameter int      DY           = 0,
   parameter          ARCHITECTURE = "BEHAVIORAL",
   parameter int      SELECT_LINES = 2,
   parameter int      DATA_WIDTH   = 8,
   parameter int      WAIT_SYNC    = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [DATA_WIDTH-1:0]                  data_in,
   input  logic                                   data_in_valid,
   input  logic                                   sync_in,
   output logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] data_out,
   output logic                                   data_out_valid,
   output logic                                   sync_out,
   output logic [SELECT_LINES-1:0]                select_out,
   output logic                                   frame_err
);

   localparam int N  = 2**SELECT_LINES;
   localparam int FW = DATA_WIDTH * N;

   generate
      if (ARCHITECTURE == "BEHAVIORAL") begin : g_beh
         typedef enum logic {S_WAIT, S_FILL} state_t;

         localparam logic [SELECT_LINES-1:0] LAST = '1;
         localparam logic [SELECT_LINES-1:0] ONE  = SELECT_LINES'(1);

         state_t                  state, state_n;
         logic [SELECT_LINES-1:0] sel_n;
         logic [SELECT_LINES-1:0] wr_lane;
         logic                    wr_en;
         logic                    synced, synced_n;
         logic                    err_n;
         logic                    strobe;
         logic [FW-1:0]           shadow, shadow_n;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state          <= (WAIT_SYNC != 0) ? S_WAIT : S_FILL;
               select_out     <= '0;
               synced         <= 1'b0;
               shadow         <= '0;
               data_out       <= '0;
               data_out_valid <= 1'b0;
               sync_out       <= 1'b0;
               frame_err      <= 1'b0;
            end else begin
               state          <= state_n;
               select_out     <= sel_n;
               synced         <= synced_n;
               shadow         <= shadow_n;
               frame_err      <= err_n;
               data_out_valid <= strobe;
               sync_out       <= strobe & synced;
               // shadow_n already includes the word completing the frame
               if (strobe)
                  data_out <= shadow_n;
            end
         end

         always_comb begin
            state_n  = state;
            sel_n    = select_out;
            synced_n = synced;
            err_n    = frame_err;
            strobe   = 1'b0;
            wr_en    = 1'b0;
            wr_lane  = select_out;

            if (sync_in) begin
               // A sync always restarts the frame; any partial frame is
               // simply abandoned (its stale lanes get overwritten later).
               if (state == S_FILL && select_out != '0)
                  err_n = 1'b1;
               state_n  = S_FILL;
               synced_n = 1'b1;
               if (data_in_valid) begin
                  wr_en   = 1'b1;
                  wr_lane = '0;
                  sel_n   = ONE;
               end else begin
                  sel_n   = '0;
               end
            end else if (data_in_valid && state == S_FILL) begin
               wr_en = 1'b1;
               if (select_out == LAST) begin
                  strobe   = 1'b1;
                  sel_n    = '0;
                  synced_n = 1'b0;
               end else begin
                  sel_n    = select_out + ONE;
               end
            end

            shadow_n = shadow;
            for (int k = 0; k < N; k++) begin
               if (wr_en && int'(wr_lane) == k)
                  shadow_n[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
         end
      end else begin : g_none
         assign data_out       = '0;
         assign data_out_valid = 1'b0;
         assign sync_out       = 1'b0;
         assign select_out     = '0;
         assign frame_err      = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        vin = 1'b0;
   logic        sin = 1'b0;
   logic [31:0] dout;
   logic        dv, so, ferr;
   logic [1:0]  sel;

   // second instance for the no-wait-for-sync variant
   logic [7:0]  din0 = 8'h00;
   logic        vin0 = 1'b0;
   logic        sin0 = 1'b0;
   logic [31:0] dout0;
   logic        dv0, so0, ferr0;
   logic [1:0]  sel0;

   int tests = 0;
   int fails = 0;

   // scoreboard entries: {sync_out, data_out}
   logic [32:0] exp_q[$];
   logic [32:0] exp0_q[$];

   always #5 clk = ~clk;

   tdm_demux #(.SELECT_LINES(2), .DATA_WIDTH(8), .WAIT_SYNC(1)) dut (
      .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin), .sync_in(sin),
      .data_out(dout), .data_out_valid(dv), .sync_out(so),
      .select_out(sel), .frame_err(ferr));

   tdm_demux #(.SELECT_LINES(2), .DATA_WIDTH(8), .WAIT_SYNC(0)) dut0 (
      .clk(clk), .rst(rst), .data_in(din0), .data_in_valid(vin0), .sync_in(sin0),
      .data_out(dout0), .data_out_valid(dv0), .sync_out(so0),
      .select_out(sel0), .frame_err(ferr0));

   // Drive one cycle, then compare any strobes against the scoreboards.
   task automatic step(input logic v, input logic s, input logic [7:0] d);
      logic [32:0] e;
      vin = v; sin = s; din = d;
      @(posedge clk); #1;
      vin = 1'b0; sin = 1'b0;
      if (dv) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got data_out=%h sync_out=%b, none expected", dout, so);
         end else begin
            e = exp_q.pop_front();
            if ({so, dout} !== e) begin
               fails++;
               $display("FAIL frame: got sync_out=%b data_out=%h, expected sync_out=%b data_out=%h",
                        so, dout, e[32], e[31:0]);
            end
         end
      end
      if (dv0) begin
         tests++;
         if (exp0_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe0: got data_out=%h", dout0);
         end else begin
            e = exp0_q.pop_front();
            if ({so0, dout0} !== e) begin
               fails++;
               $display("FAIL frame0: got sync_out=%b data_out=%h, expected sync_out=%b data_out=%h",
                        so0, dout0, e[32], e[31:0]);
            end
         end
      end
   endtask

   task automatic step0(input logic v, input logic [7:0] d);
      vin0 = v; din0 = d;
      step(1'b0, 1'b0, 8'h00);
      vin0 = 1'b0;
   endtask

   task automatic drain(input string name);
      tests++;
      if (exp_q.size() != 0 || exp0_q.size() != 0) begin
         fails++;
         $display("FAIL %s_missing_strobe: %0d/%0d expected frames not seen", name,
                  exp_q.size(), exp0_q.size());
      end
      exp_q.delete();
      exp0_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      tests++;
      if ({dout, dv, so, sel, ferr} !== 37'd0) begin
         fails++;
         $display("FAIL reset_outputs: got dout=%h dv=%b so=%b sel=%0d ferr=%b, expected all 0",
                  dout, dv, so, sel, ferr);
      end
      tests++;
      if ({dout0, dv0, so0, sel0, ferr0} !== 37'd0) begin
         fails++;
         $display("FAIL reset_outputs0: got dout=%h sel=%0d, expected all 0", dout0, sel0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_wait_sync;
      step(1, 0, 8'hAA);
      step(1, 0, 8'hBB);
      tests++;
      if (sel !== 2'd0) begin
         fails++;
         $display("FAIL wait_drop_select: got %0d expected 0", sel);
      end
      exp_q.push_back({1'b1, 32'h44332211});
      step(1, 1, 8'h11);
      step(1, 0, 8'h22);
      step(1, 0, 8'h33);
      step(1, 0, 8'h44);
      step(0, 0, 8'h00);
      tests++;
      if (dout !== 32'h44332211 || dv !== 1'b0) begin
         fails++;
         $display("FAIL hold_frame: got dout=%h dv=%b expected dout=44332211 dv=0", dout, dv);
      end
      tests++;
      if (ferr !== 1'b0) begin
         fails++;
         $display("FAIL no_err_t1: got frame_err=%b expected 0", ferr);
      end
      drain("wait_sync");
   endtask

   task automatic test_back_to_back;
      exp_q.push_back({1'b1, 32'h04030201});
      exp_q.push_back({1'b0, 32'h08070605});
      for (int i = 1; i <= 8; i++) begin
         step(1, (i == 1), 8'(i));
         tests++;
         if (dv !== (i == 4 || i == 8)) begin
            fails++;
            $display("FAIL b2b_strobe_timing: word %0d dv=%b", i, dv);
         end
      end
      step(0, 0, 8'h00);
      drain("back_to_back");
   endtask

   task automatic test_frame_err;
      step(1, 1, 8'h10);
      step(1, 0, 8'h20);
      tests++;
      if (ferr !== 1'b0) begin
         fails++;
         $display("FAIL err_early: got frame_err=%b expected 0", ferr);
      end
      exp_q.push_back({1'b1, 32'h60504030});
      step(1, 1, 8'h30);
      tests++;
      if (ferr !== 1'b1 || sel !== 2'd1) begin
         fails++;
         $display("FAIL err_set: got frame_err=%b sel=%0d expected 1,1", ferr, sel);
      end
      step(1, 0, 8'h40);
      step(1, 0, 8'h50);
      step(1, 0, 8'h60);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      tests++;
      if (ferr !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky: got frame_err=%b expected 1", ferr);
      end
      drain("frame_err");
   endtask

   task automatic test_gaps;
      logic [1:0] exp_sel[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      tests++;
      if (sel !== 2'd0) begin
         fails++;
         $display("FAIL gap_sel_start: got %0d expected 0", sel);
      end
      exp_q.push_back({1'b1, 32'hA3A2A1A0});
      for (int i = 0; i < 4; i++) begin
         step(1, (i == 0), 8'hA0 + 8'(i));
         tests++;
         if (sel !== exp_sel[i]) begin
            fails++;
            $display("FAIL gap_select: word %0d got sel=%0d expected %0d", i, sel, exp_sel[i]);
         end
         step(0, 0, 8'hEE);
         tests++;
         if (sel !== exp_sel[i]) begin
            fails++;
            $display("FAIL gap_hold_select: word %0d got sel=%0d expected %0d", i, sel, exp_sel[i]);
         end
      end
      drain("gaps");
   endtask

   task automatic test_reset_mid_frame;
      step(1, 1, 8'h55);
      step(1, 0, 8'h66);
      rst = 1'b1;
      #1;
      tests++;
      if ({dout, dv, so, sel, ferr} !== 37'd0) begin
         fails++;
         $display("FAIL midreset_outputs: got dout=%h dv=%b sel=%0d ferr=%b expected all 0",
                  dout, dv, sel, ferr);
      end
      step(1, 0, 8'h77);
      step(1, 0, 8'h88);
      rst = 1'b0;
      exp_q.push_back({1'b1, 32'hC3C2C1C0});
      for (int i = 0; i < 4; i++) step(1, (i == 0), 8'hC0 + 8'(i));
      step(0, 0, 8'h00);
      tests++;
      if (ferr !== 1'b0) begin
         fails++;
         $display("FAIL midreset_err: got frame_err=%b expected 0", ferr);
      end
      drain("reset_mid_frame");
   endtask

   task automatic test_no_wait;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp0_q.push_back({1'b0, 32'h04030201});
      for (int i = 1; i <= 4; i++) step0(1, 8'(i));
      step0(0, 8'h00);
      tests++;
      if (dout0 !== 32'h04030201) begin
         fails++;
         $display("FAIL nowait_hold: got %h expected 04030201", dout0);
      end
      drain("no_wait");
   endtask

   initial begin
      test_reset;
      test_wait_sync;
      test_back_to_back;
      test_frame_err;
      test_gaps;
      test_reset_mid_frame;
      test_no_wait;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
